// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS control sequencer; define MC_MEM_WAIT_EN to honour mem_ready wait states
module mc_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] operation,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       i_or_d,
    output logic       mem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       imm_zext,
    output logic [2:0] alu_control,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state
);
    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
                           S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_RTEXEC = 4'd6, S_RTWB = 4'd7,
                           S_BRANCH = 4'd8, S_IEXEC = 4'd9, S_IWB = 4'd10, S_JUMP = 4'd11,
                           S_JR = 4'd12, S_JAL = 4'd13;
    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                           OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_LW = 6'b100011,
                           OP_SW = 6'b101011;
    localparam logic [5:0] F_JR = 6'b001000;
    localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010, A_SLL = 3'b011,
                           A_SRL = 3'b100, A_SRA = 3'b101, A_SUB = 3'b110, A_SLT = 3'b111;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_ready;
    logic       w_rt_legal;
    logic       w_illegal;
    logic       w_shamt;
    logic [2:0] w_rt_alu;

`ifdef MC_MEM_WAIT_EN
    assign w_ready = mem_ready;
`else
    logic w_unused_ready;
    assign w_unused_ready = mem_ready;
    assign w_ready = 1'b1;
`endif

    // R-type function decode: legality and ALU operation (variable shifts share codes with shamt shifts)
    always_comb begin
        w_rt_legal = 1'b1;
        w_rt_alu   = A_ADD;
        case (func)
            6'b000000, 6'b000100: w_rt_alu = A_SLL;
            6'b000010, 6'b000110: w_rt_alu = A_SRL;
            6'b000011, 6'b000111: w_rt_alu = A_SRA;
            F_JR, 6'b100000:      w_rt_alu = A_ADD;
            6'b100010:            w_rt_alu = A_SUB;
            6'b100100:            w_rt_alu = A_AND;
            6'b100101:            w_rt_alu = A_OR;
            6'b101010:            w_rt_alu = A_SLT;
            default:              w_rt_legal = 1'b0;
        endcase
    end

    assign w_shamt   = func[5:2] == 4'b0000;
    assign w_illegal = (operation == OP_R) ? !w_rt_legal :
                       !(operation inside {OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW});
    assign state     = r_state;

    // Next-state selection; memory states hold until the access completes
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = w_ready ? S_DECODE : S_FETCH;
            S_DECODE: w_next = w_illegal ? S_FETCH :
                               (operation == OP_LW || operation == OP_SW) ? S_MEMADR :
                               (operation == OP_R) ? ((func == F_JR) ? S_JR : S_RTEXEC) :
                               (operation == OP_BEQ || operation == OP_BNE) ? S_BRANCH :
                               (operation == OP_J) ? S_JUMP :
                               (operation == OP_JAL) ? S_JAL : S_IEXEC;
            S_MEMADR: w_next = (operation == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = w_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_next = w_ready ? S_FETCH : S_MEMWR;
            S_RTEXEC: w_next = S_RTWB;
            S_IEXEC:  w_next = S_IWB;
            default:  w_next = S_FETCH;
        endcase
    end

    // State register; reset abandons any in-flight instruction
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    // Datapath controls per state; write/strobe enables are suppressed while reset is held
    always_comb begin
        mem_req     = 1'b0;
        i_or_d      = 1'b0;
        mem_we      = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 2'd0;
        reg_we      = 1'b0;
        reg_dst     = 2'd0;
        mem_to_reg  = 2'd0;
        alu_src_a   = 2'd0;
        alu_src_b   = 2'd0;
        imm_zext    = 1'b0;
        alu_control = A_AND;
        retire      = 1'b0;
        illegal     = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req     = 1'b1;
                ir_we       = w_ready;
                pc_we       = w_ready;
                alu_src_b   = 2'd1;
                alu_control = A_ADD;
            end
            S_DECODE: begin
                alu_src_b   = 2'd3;
                alu_control = A_ADD;
                illegal     = w_illegal;
            end
            S_MEMADR: begin
                alu_src_a   = 2'd1;
                alu_src_b   = 2'd2;
                alu_control = A_ADD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
            end
            S_MEMWB: begin
                reg_we     = 1'b1;
                mem_to_reg = 2'd1;
                retire     = 1'b1;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                mem_we  = 1'b1;
                retire  = w_ready;
            end
            S_RTEXEC: begin
                alu_src_a   = w_shamt ? 2'd2 : 2'd1;
                alu_control = w_rt_alu;
            end
            S_RTWB: begin
                reg_we  = 1'b1;
                reg_dst = 2'd1;
                retire  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 2'd1;
                alu_control = A_SUB;
                pc_src      = 2'd1;
                pc_we       = (operation == OP_BNE) ? !zero : zero;
                retire      = 1'b1;
            end
            S_IEXEC: begin
                alu_src_a   = 2'd1;
                alu_src_b   = 2'd2;
                alu_control = (operation == OP_ANDI) ? A_AND : (operation == OP_ORI) ? A_OR : A_ADD;
                imm_zext    = operation == OP_ANDI || operation == OP_ORI;
            end
            S_IWB: begin
                reg_we = 1'b1;
                retire = 1'b1;
            end
            S_JUMP: begin
                pc_we  = 1'b1;
                pc_src = 2'd2;
                retire = 1'b1;
            end
            S_JR: begin
                pc_we  = 1'b1;
                pc_src = 2'd3;
                retire = 1'b1;
            end
            S_JAL: begin
                pc_we      = 1'b1;
                pc_src     = 2'd2;
                reg_we     = 1'b1;
                reg_dst    = 2'd2;
                mem_to_reg = 2'd2;
                retire     = 1'b1;
            end
            default: ;
        endcase
        if (!rst_n) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            reg_we  = 1'b0;
            retire  = 1'b0;
            illegal = 1'b0;
        end
    end
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: instruction-level model of the multicycle sequencer checked every cycle
module tb_mc_control_fsm;
    typedef struct packed {
        logic [3:0] st;
        logic       mreq, iod, mwe, irwe, pcwe;
        logic [1:0] pcs;
        logic       rwe;
        logic [1:0] rdst, m2r, asa, asb;
        logic       iz;
        logic [2:0] alu;
        logic       ret, ill;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst_n, zero, mem_ready;
    logic [5:0] operation, func;
    logic       mem_req, i_or_d, mem_we, ir_we, pc_we, reg_we, imm_zext, retire, illegal;
    logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_a, alu_src_b;
    logic [2:0] alu_control;
    logic [3:0] state;
    rec_t       act;
    rec_t       q[$];
    logic       rq[$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .operation(operation), .func(func), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .i_or_d(i_or_d), .mem_we(mem_we),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_zext(imm_zext), .alu_control(alu_control), .retire(retire), .illegal(illegal),
        .state(state)
    );

    assign act = {state, mem_req, i_or_d, mem_we, ir_we, pc_we, pc_src, reg_we, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, imm_zext, alu_control, retire, illegal};

    function automatic string mnem(input logic [5:0] op, fn);
        case (op)
            6'b100011: return "lw";
            6'b101011: return "sw";
            6'b000100: return "beq";
            6'b000101: return "bne";
            6'b001000: return "addi";
            6'b001100: return "andi";
            6'b001101: return "ori";
            6'b000010: return "j";
            6'b000011: return "jal";
            6'b000000:
                case (fn)
                    6'b000000: return "sll";
                    6'b000010: return "srl";
                    6'b000011: return "sra";
                    6'b000100: return "sllv";
                    6'b000110: return "srlv";
                    6'b000111: return "srav";
                    6'b001000: return "jr";
                    6'b100000: return "add";
                    6'b100010: return "sub";
                    6'b100100: return "and";
                    6'b100101: return "or";
                    6'b101010: return "slt";
                    default:   return "ill";
                endcase
            default: return "ill";
        endcase
    endfunction

    function automatic logic [2:0] aluc(input string m);
        if (m == "and" || m == "andi") return 3'b000;
        if (m == "or" || m == "ori") return 3'b001;
        if (m == "sll" || m == "sllv") return 3'b011;
        if (m == "srl" || m == "srlv") return 3'b100;
        if (m == "sra" || m == "srav") return 3'b101;
        if (m == "sub") return 3'b110;
        if (m == "slt") return 3'b111;
        return 3'b010;
    endfunction

    function automatic void push(input rec_t r, input logic rdy);
        q.push_back(r);
        rq.push_back(rdy);
    endfunction

    // Expected cycle-by-cycle outputs of one instruction, with fst/mst not-ready cycles in fetch/memory
    function automatic void plan(input logic [5:0] op, fn, input logic z, input int fst, mst);
        rec_t  r;
        string m = mnem(op, fn);
        q.delete();
        rq.delete();
        for (int i = 0; i <= fst; i++) begin
            r = '0; r.mreq = 1; r.irwe = (i == fst); r.pcwe = (i == fst); r.asb = 1; r.alu = 3'b010;
            push(r, i == fst);
        end
        r = '0; r.st = 1; r.asb = 3; r.alu = 3'b010; r.ill = (m == "ill");
        push(r, 1);
        if (m == "ill") return;
        if (m == "lw" || m == "sw") begin
            r = '0; r.st = 2; r.asa = 1; r.asb = 2; r.alu = 3'b010;
            push(r, 1);
            for (int i = 0; i <= mst; i++) begin
                r = '0; r.st = (m == "lw") ? 3 : 5; r.mreq = 1; r.iod = 1;
                r.mwe = (m == "sw"); r.ret = (m == "sw") && (i == mst);
                push(r, i == mst);
            end
            if (m == "lw") begin
                r = '0; r.st = 4; r.rwe = 1; r.m2r = 1; r.ret = 1;
                push(r, 1);
            end
        end else if (m == "beq" || m == "bne") begin
            r = '0; r.st = 8; r.asa = 1; r.alu = 3'b110; r.pcs = 1; r.ret = 1;
            r.pcwe = (m == "beq") ? z : !z;
            push(r, 1);
        end else if (m == "addi" || m == "andi" || m == "ori") begin
            r = '0; r.st = 9; r.asa = 1; r.asb = 2; r.alu = aluc(m); r.iz = (m != "addi");
            push(r, 1);
            r = '0; r.st = 10; r.rwe = 1; r.ret = 1;
            push(r, 1);
        end else if (m == "j" || m == "jal") begin
            r = '0; r.st = (m == "j") ? 11 : 13; r.pcwe = 1; r.pcs = 2; r.ret = 1;
            if (m == "jal") begin r.rwe = 1; r.rdst = 2; r.m2r = 2; end
            push(r, 1);
        end else if (m == "jr") begin
            r = '0; r.st = 12; r.pcwe = 1; r.pcs = 3; r.ret = 1;
            push(r, 1);
        end else begin
            r = '0; r.st = 6; r.alu = aluc(m);
            r.asa = (m == "sll" || m == "srl" || m == "sra") ? 2 : 1;
            push(r, 1);
            r = '0; r.st = 7; r.rwe = 1; r.rdst = 1; r.ret = 1;
            push(r, 1);
        end
    endfunction

    task automatic chk(input string n, input logic ok, input logic [31:0] a, e);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", n, a, e);
        end
    endtask

    task automatic ck_en(input string n, input logic [3:0] st);
        logic [10:0] a;
        a = {state, mem_req, mem_we, ir_we, pc_we, reg_we, retire, illegal};
        chk(n, a === {st, 7'b0}, 32'(a), 32'({st, 7'b0}));
    endtask

    // Starts just after a rising edge in FETCH; compares every cycle of the instruction at the falling edge
    task automatic run(input string n, input logic [5:0] op, fn, input logic z, input int fst, mst, lim);
        operation = op;
        func = fn;
        zero = z;
        plan(op, fn, z, fst, mst);
        for (int i = 0; i < q.size() && i < lim; i++) begin
            mem_ready = rq[i];
            @(negedge clk);
            chk($sformatf("%s.c%0d", n, i), act === q[i], 32'(act), 32'(q[i]));
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b1;
    endtask

    localparam int N = 25;
    string      t_n   [N] = '{"lw", "sw", "add", "sub", "and", "or", "slt", "sll", "srl", "sra", "sllv",
                              "srlv", "srav", "jr", "beq1", "beq0", "bne1", "bne0", "addi", "andi", "ori",
                              "j", "jal", "illop", "illfn"};
    logic [5:0] t_op  [N] = '{6'o43, 6'o53, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                              0, 0, 0, 6'o04, 6'o04, 6'o05, 6'o05, 6'o10, 6'o14, 6'o15,
                              6'o02, 6'o03, 6'o77, 0};
    logic [5:0] t_fn  [N] = '{0, 0, 6'o40, 6'o42, 6'o44, 6'o45, 6'o52, 6'o00, 6'o02, 6'o03, 6'o04,
                              6'o06, 6'o07, 6'o10, 0, 0, 0, 0, 0, 0, 0,
                              0, 0, 0, 6'o17};
    logic       t_z   [N] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    int         t_len [N] = '{5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 3, 3, 3, 3, 3, 4, 4, 4, 3, 3, 2, 2};

    initial begin
        rst_n = 1'b0;
        operation = 6'b100011;
        func = 6'b0;
        zero = 1'b0;
        mem_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            ck_en("reset_hold", 4'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            run(t_n[i], t_op[i], t_fn[i], t_z[i], 0, 0, 99);
            chk({"len.", t_n[i]}, q.size() == t_len[i], 32'(q.size()), 32'(t_len[i]));
            if (t_n[i] == "beq1") chk("pin.beq1_pcwe", q[2].pcwe == 1'b1, 32'(q[2].pcwe), 32'd1);
            if (t_n[i] == "bne1") chk("pin.bne1_pcwe", q[2].pcwe == 1'b0, 32'(q[2].pcwe), 32'd0);
            if (t_n[i] == "lw") chk("pin.lw_wb", {q[4].rwe, q[4].m2r} == 3'b101, 32'({q[4].rwe, q[4].m2r}), 32'd5);
        end
        run("lw_abort", 6'b100011, 6'b0, 1'b0, 0, 0, 3);
        rst_n = 1'b0;
        @(negedge clk);
        ck_en("abort_memrd", 4'd3);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`ifdef MC_MEM_WAIT_EN
        run("sw_wait", 6'b101011, 6'b0, 1'b0, 0, 3, 99);
        chk("len.sw_wait", q.size() == 7, 32'(q.size()), 32'd7);
        run("fetch_wait", 6'b000000, 6'b100000, 1'b0, 2, 0, 99);
        chk("len.fetch_wait", q.size() == 6, 32'(q.size()), 32'd6);
`endif
        run("add_after", 6'b000000, 6'b100000, 1'b0, 0, 0, 99);
        @(negedge clk);
        chk("final_fetch", state === 4'd0, 32'(state), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multicycle sequencer for the MIPS core: decodes `operation`/`func` held in the instruction register and steps a shared-ALU, shared-memory datapath through fetch, decode, execute, memory and writeback cycles. It drives every datapath enable and mux select, and resolves `beq`/`bne` using the ALU zero flag. It sits beside the datapath's PC, IR, MDR and ALUOut registers and replaces the single-cycle decoder for the multicycle core variant.

## Interface
Parameters:
- none; all encodings fixed.

Ports:
- `clk`  in  1  core clock; all state changes on rising edge.
- `rst_n`  in  1  synchronous reset, active low.
- `operation`  in  6  IR[31:26].
- `func`  in  6  IR[5:0].
- `zero`  in  1  ALU result == 0, valid in BRANCH.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access active.
- `i_or_d`  out  1  0 = address from PC, 1 = address from ALUOut.
- `mem_we`  out  1  memory write.
- `ir_we`  out  1  load IR.
- `pc_we`  out  1  load PC.
- `pc_src`  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target `{PC[31:28], IR[25:0], 2'b00}`, 3 = rs.
- `reg_we`  out  1  register file write.
- `reg_dst`  out  2  0 = rt, 1 = rd, 2 = $31.
- `mem_to_reg`  out  2  0 = ALUOut, 1 = MDR, 2 = PC.
- `alu_src_a`  out  2  0 = PC, 1 = rs, 2 = shamt (zero-extended).
- `alu_src_b`  out  2  0 = rt, 1 = 4, 2 = extended immediate, 3 = sign-extended immediate << 2.
- `imm_zext`  out  1  immediate is zero-extended (andi, ori).
- `alu_control`  out  3  000 and, 001 or, 010 add, 011 sll, 100 srl, 101 sra, 110 sub, 111 slt.
- `retire`  out  1  one-cycle pulse on the last cycle of each instruction.
- `illegal`  out  1  one-cycle pulse in DECODE for an unsupported op/func.
- `state`  out  4  current state, for debug.

## Operation
States and encodings:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXEC=6, RTWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11, JR=12, JAL=13.

Default output for any signal not listed below is 0.

Per-state outputs and transitions:
- FETCH: mem_req=1, i_or_d=0, ir_we, pc_we, alu_src_a=0, alu_src_b=1, add, pc_src=0. IR and PC update only on a completed access. Next state is DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, add (branch target into ALUOut).
  - lw/sw → MEMADR.
  - R-type: jr (func 001000) → JR; all other legal funcs → RTEXEC.
  - beq/bne → BRANCH.
  - addi/andi/ori → IEXEC.
  - j → JUMP.
  - jal (000011) → JAL.
  - Any other op/func: `illegal`=1, next state FETCH, no write.
- MEMADR: alu_src_a=1, alu_src_b=2, add. lw → MEMRD; sw → MEMWR.
- MEMRD: mem_req=1, i_or_d=1. Next state MEMWB.
- MEMWB: reg_we, reg_dst=0, mem_to_reg=1, retire.
- MEMWR: mem_req=1, i_or_d=1, mem_we, retire.
- RTEXEC:
  - sll/srl/sra: alu_src_a=2, alu_src_b=0, alu_control 011/100/101.
  - All others: alu_src_a=1, alu_src_b=0, alu_control from func: and, or, add, sllv→011, srlv→100, srav→101, sub, slt.
- RTWB: reg_we, reg_dst=1, mem_to_reg=0, retire.
- BRANCH: alu_src_a=1, alu_src_b=0, sub, pc_src=1, retire. pc_we = zero for beq, !zero for bne.
- IEXEC: alu_src_a=1, alu_src_b=2, alu_control add/and/or. imm_zext=1 for andi/ori.
- IWB: reg_we, reg_dst=0, mem_to_reg=0, retire.
- JUMP: pc_we, pc_src=2, retire.
- JR: pc_we, pc_src=3, retire.
- JAL: pc_we, pc_src=2, reg_we, reg_dst=2, mem_to_reg=2, retire. The PC mux source still holds PC+4, so $31 receives the return address.

All terminal states return to FETCH.

## Timing
- Outputs are combinational from `state`, `operation`, `func` and `zero` (Moore/Mealy mix). There are no output registers.
- Reset:
  - When `rst_n` is low at an edge, state ← FETCH.
  - While `rst_n` is low, pc_we, ir_we, reg_we, mem_we, mem_req, retire and illegal are forced to 0.
  - Reset asserted mid-instruction abandons the instruction with no partial write.
- Latency with zero wait states:
  - lw: 5 cycles.
  - sw, R-type, addi/andi/ori: 4 cycles.
  - beq/bne, j, jal, jr: 3 cycles.
  - Illegal op/func: 2 cycles.
- `operation`/`func` must be stable from DECODE through the terminal state; IR is written only in FETCH.

## Configuration
`MC_MEM_WAIT_EN` controls memory wait states.
- Defined:
  - FETCH, MEMRD and MEMWR hold while `mem_ready`=0.
  - In FETCH, ir_we and pc_we are asserted only in the cycle `mem_ready`=1.
  - In MEMWR, mem_we and mem_req are held and retire pulses only when `mem_ready`=1.
  - MEMRD advances when `mem_ready`=1.
- Undefined:
  - `mem_ready` is ignored; every memory state lasts exactly one cycle and the latencies above are exact.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with lw in IR → state=0 and all enables 0; release → FETCH outputs (pc_we=1, alu_src_b=1, alu_control=010).
- lw: sequence 0,1,2,3,4; reg_we only in state 4 with mem_to_reg=1, reg_dst=0; one retire pulse; total 5 cycles.
- beq/bne: beq with zero=1 → pc_we=1, pc_src=1 in state 8; bne with zero=1 → pc_we=0; both retire after 3 cycles.
- Shifts and jumps:
  - sll (func 000000) → RTEXEC with alu_src_a=2, alu_control=011.
  - jr → state 12, pc_src=3.
  - jal → state 13, reg_dst=2, mem_to_reg=2, reg_we=1.
- Illegal: opcode 111111 → illegal=1 in DECODE, no reg_we/mem_we, back to FETCH the next cycle.
- With `MC_MEM_WAIT_EN`: mem_ready low 3 cycles during sw MEMWR → mem_we held 4 cycles, retire only on the ready cycle; fetch stall keeps pc_we=0 until ready.
